// File: rtl/tt_microtile_pwm_bank_pkg.sv
// Shared constants and elaboration helpers for the PWM microtile.
package tt_microtile_pkg;

    localparam int unsigned PIN_W      = 8;
    localparam int unsigned STROBE_BIT = 7;
    localparam int unsigned ENABLE_BIT = 6;
    localparam int unsigned MARKER_BIT = 7;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned p = 1; p < v; p = p << 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Address, data, strobe and enable must all fit on the 8-bit pin bus.
    function automatic logic params_ok(input int unsigned width, input int unsigned channels);
        return ((channels == 2) || (channels == 4)) && (width >= 1)
               && ((clog2(channels) + width + 2) <= PIN_W);
    endfunction

endpackage

// File: rtl/tt_microtile_pwm_bank_if.sv
// Tile pin bus: ui_in from the pads, uo_out back to the pads.
interface tt_microtile_pwm_bank_if;
    import tt_microtile_pkg::*;

    logic [PIN_W-1:0] ui_in;
    logic [PIN_W-1:0] uo_out;

    modport master (output ui_in, input uo_out);
    modport slave  (input ui_in, output uo_out);

endinterface

// File: rtl/tt_microtile_pwm_bank_pwm_channel.sv
// One PWM channel: shadow duty, period-aligned active duty, registered compare.
module pwm_channel #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] data,
    input  logic             load,
    input  logic [WIDTH-1:0] cnt,
    input  logic             en,
    output logic             pwm
);

    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] active;

    // active samples the pre-write shadow when a write and a load share an edge
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
            active <= '0;
            pwm    <= 1'b0;
        end else begin
            if (wr_en) begin
                shadow <= data;
            end
            if (load) begin
                active <= shadow;
            end
            pwm <= en & (cnt < active);
        end
    end

endmodule

// File: rtl/tt_microtile_pwm_bank.sv
// Multi-channel PWM tile: synchronised pin-bus writes, shared counter, period marker.
module tt_microtile_pwm_bank
    import tt_microtile_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned CHANNELS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    tt_microtile_pwm_bank_if.slave   bus
);

    localparam int unsigned AW = clog2(CHANNELS);
    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    if (!params_ok(WIDTH, CHANNELS)) begin : g_param_check
        $error("tt_microtile_pwm_bank: unsupported WIDTH/CHANNELS combination");
    end

    logic [PIN_W-1:0]    s1;
    logic [PIN_W-1:0]    s2;
    logic                s2_d;
    logic [WIDTH-1:0]    cnt;
    logic                marker;
    logic [CHANNELS-1:0] pwm;

    logic                wr_c;
    logic                en_c;
    logic                load_c;
    logic [AW-1:0]       addr_c;
    logic [WIDTH-1:0]    data_c;
    logic [PIN_W-1:0]    out_c;

    // Two-flop synchroniser on the whole pin bus plus strobe delay for edge detect
    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= '0;
            s2   <= '0;
            s2_d <= 1'b0;
        end else begin
            s1   <= bus.ui_in;
            s2   <= s1;
            s2_d <= s2[STROBE_BIT];
        end
    end

    assign wr_c   = s2[STROBE_BIT] & ~s2_d;
    assign en_c   = s2[ENABLE_BIT];
    assign addr_c = s2[WIDTH+AW-1:WIDTH];
    assign data_c = s2[WIDTH-1:0];
    assign load_c = en_c ? (cnt == CNT_MAX) : 1'b1;

    // Free-running period counter, parked at zero while disabled
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            marker <= 1'b0;
        end else begin
            cnt    <= en_c ? (cnt + WIDTH'(1)) : '0;
            marker <= en_c & (cnt == '0);
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        pwm_channel #(
            .WIDTH (WIDTH)
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .wr_en (wr_c && (addr_c == AW'(i))),
            .data  (data_c),
            .load  (load_c),
            .cnt   (cnt),
            .en    (en_c),
            .pwm   (pwm[i])
        );
    end

    always_comb begin
        out_c                      = '0;
        out_c[CHANNELS-1:0]        = pwm;
        out_c[MARKER_BIT]          = marker;
    end

    assign bus.uo_out = out_c;

endmodule

// File: tb/tb_tt_microtile_pwm_bank.sv
// Directed and randomized checks of the PWM tile against a period-level reference model.
module tb_tt_microtile_pwm_bank;

    localparam int PERIOD = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tt_microtile_pwm_bank_if bus ();

    tt_microtile_pwm_bank #(
        .WIDTH    (4),
        .CHANNELS (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int acc [8];
    logic [7:0] mark_uo;

    // Reference state: input history seen by the tile, enabled run length, duty tables
    logic [7:0] pipe [$];
    int         run;
    logic [3:0] duty_next [4];
    logic [3:0] duty_now  [4];
    logic [7:0] exp_uo;

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        pipe = '{8'h00, 8'h00, 8'h00};
        run  = 0;
        for (int i = 0; i < 4; i++) begin
            duty_next[i] = 4'd0;
            duty_now[i]  = 4'd0;
        end
        exp_uo = 8'h00;
    endtask

    // Tile sees pins two edges late; phase is the enabled run length modulo the period.
    task automatic model_edge(input logic [7:0] u, input logic r);
        logic [7:0] seen;
        logic       seen_en;
        logic       new_write;
        int         phase;
        if (r) begin
            model_reset();
        end else begin
            seen      = pipe[1];
            seen_en   = seen[6];
            new_write = seen[7] && !pipe[0][7];
            phase     = run % PERIOD;
            exp_uo    = 8'h00;
            for (int i = 0; i < 4; i++) begin
                exp_uo[i] = seen_en && (phase < int'(duty_now[i]));
            end
            exp_uo[7] = seen_en && (phase == 0);
            if (!seen_en || phase == PERIOD - 1) begin
                duty_now = duty_next;
            end
            if (new_write) begin
                duty_next[seen[5:4]] = seen[3:0];
            end
            run = seen_en ? run + 1 : 0;
            void'(pipe.pop_front());
            pipe.push_back(u);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(bus.ui_in, rst);
        #1;
        cyc++;
        check8($sformatf("uo_out@%0d", cyc), bus.uo_out, exp_uo);
        for (int i = 0; i < 8; i++) begin
            acc[i] += int'(bus.uo_out[i]);
        end
    endtask

    // Advance to the next marker cycle, restarting the per-bit high counters there
    task automatic sync_to_marker(input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.uo_out[7] !== 1'b1 && n < 40);
        check8({tag, "_marker_seen"}, {7'd0, bus.uo_out[7]}, 8'h01);
        mark_uo = bus.uo_out;
        for (int i = 0; i < 8; i++) begin
            acc[i] = int'(bus.uo_out[i]);
        end
    endtask

    task automatic write_ch(input int ch, input int val, input logic en);
        bus.ui_in = {1'b1, en, 2'(ch), 4'(val)};
        repeat (4) tick();
        bus.ui_in[7] = 1'b0;
        repeat (2) tick();
    endtask

    initial begin
        model_reset();
        for (int i = 0; i < 8; i++) acc[i] = 0;
        mark_uo = 8'h00;

        // Reset with garbage on the pins
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.ui_in = 8'($urandom);
            tick();
        end
        check8("reset_uo", bus.uo_out, 8'h00);
        check_int("reset_cnt", int'(dut.cnt), 0);
        rst = 1'b0;
        bus.ui_in = 8'h00;
        tick();

        // Basic duty programming while disabled, then enable
        write_ch(0, 4, 1'b0);
        write_ch(1, 8, 1'b0);
        write_ch(2, 0, 1'b0);
        write_ch(3, 15, 1'b0);
        bus.ui_in = 8'h40;
        sync_to_marker("basic");
        repeat (PERIOD - 1) tick();
        check_int("basic_ch0", acc[0], 4);
        check_int("basic_ch1", acc[1], 8);
        check_int("basic_ch2", acc[2], 0);
        check_int("basic_ch3", acc[3], 15);
        check_int("basic_marker", acc[7], 1);
        check8("basic_align", mark_uo, 8'h8B);

        // Double buffer: mid-period write lands next period
        sync_to_marker("dbuf");
        for (int i = 1; i < PERIOD; i++) begin
            if (i == 3) bus.ui_in = 8'hCC;
            if (i == 7) bus.ui_in = 8'h4C;
            tick();
        end
        check_int("dbuf_cur", acc[0], 4);
        sync_to_marker("dbuf2");
        repeat (PERIOD - 1) tick();
        check_int("dbuf_next", acc[0], 12);

        // Shadow write on the same edge as the wrap load
        sync_to_marker("wrap");
        for (int i = 1; i < PERIOD; i++) begin
            if (i == 13) bus.ui_in = 8'hD3;
            tick();
        end
        check_int("wrap_cur", acc[1], 8);
        sync_to_marker("wrap2");
        bus.ui_in = 8'h53;
        repeat (PERIOD - 1) tick();
        check_int("wrap_next", acc[1], 8);
        sync_to_marker("wrap3");
        repeat (PERIOD - 1) tick();
        check_int("wrap_after", acc[1], 3);

        // Held strobe with changing data writes once
        bus.ui_in = 8'hE3;
        for (int i = 0; i < 40; i++) begin
            if (i == 10) bus.ui_in = 8'hE9;
            tick();
        end
        bus.ui_in = 8'h69;
        sync_to_marker("held");
        repeat (PERIOD - 1) tick();
        sync_to_marker("held2");
        repeat (PERIOD - 1) tick();
        check_int("held_ch2", acc[2], 3);

        // Disable mid-period, then reset and re-enable without writes
        sync_to_marker("dis");
        repeat (6) tick();
        check_int("dis_cnt", int'(dut.cnt), 7);
        bus.ui_in = 8'h00;
        repeat (3) tick();
        check8("dis_uo", bus.uo_out, 8'h00);
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        bus.ui_in = 8'h40;
        sync_to_marker("rearm");
        repeat (PERIOD - 1) tick();
        check_int("rearm_pwm", acc[0] + acc[1] + acc[2] + acc[3], 0);
        check_int("rearm_marker", acc[7], 1);

        // Randomized writes, enable toggles and one mid-run reset
        for (int n = 0; n < 40; n++) begin
            logic en_r;
            en_r = ($urandom_range(0, 7) != 0);
            bus.ui_in = {1'b1, en_r, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
            repeat (4) tick();
            bus.ui_in[7] = 1'b0;
            repeat ($urandom_range(1, 20)) tick();
            if (n == 20) begin
                rst = 1'b1;
                bus.ui_in = 8'($urandom);
                tick();
                rst = 1'b0;
                bus.ui_in = 8'h40;
            end
        end
        bus.ui_in = 8'h40;
        repeat (2 * PERIOD) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
